// File: rtl/lcb_rx_collector_if.sv
// Bundles the per-channel byte strobes coming from the UART receivers and the
// drained byte stream going out to the orbital packers.
// The collector uses the master view; whoever feeds and consumes it uses slave.
interface lcb_rx_collector_if #(
  parameter int CH        = 5,
  parameter int FRAME_LEN = 16
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [CH-1:0]   iValid;
  logic [8*CH-1:0] iData;
  logic            iSync;

  logic            oValid;
  logic [7:0]      oData;
  logic [CW-1:0]   oCh;
  logic [IW-1:0]   oIdx;
  logic            oFill;
  logic            oDone;
  logic            oBusy;
  logic [CH-1:0]   oComplete;
  logic [CH-1:0]   oTmo;
  logic [CH-1:0]   oOvf;

  modport master (
    input  iValid, iData, iSync,
    output oValid, oData, oCh, oIdx, oFill, oDone, oBusy,
    output oComplete, oTmo, oOvf
  );

  modport slave (
    output iValid, iData, iSync,
    input  oValid, oData, oCh, oIdx, oFill, oDone, oBusy,
    input  oComplete, oTmo, oOvf
  );
endinterface

// File: rtl/lcb_rx_collector.sv
// Multi-channel LCB answer-frame collector: buffers one frame per UART channel
// and, on frame sync, drains all channels 0..CH-1 as a byte-per-clock stream.
// Missing bytes come out as FILL; stalled partial frames are locked by a
// per-channel inter-byte timeout; dropped bytes are reported as sticky overflow.
//
//   state | meaning
//   IDLE  | collecting bytes, waiting for iSync
//   DRAIN | streaming CH*FRAME_LEN bytes; all incoming bytes dropped
module lcb_rx_collector #(
  parameter int         CH        = 5,
  parameter int         FRAME_LEN = 16,
  parameter int         TIMEOUT   = 800,
  parameter logic [7:0] FILL      = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  lcb_rx_collector_if.master bus
);

  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int IW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CNTW = $clog2(FRAME_LEN + 1);
  localparam int IDW  = $clog2(TIMEOUT);

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FRAME_LEN);
  localparam logic [IDW-1:0]  IDL_LAST = IDW'(TIMEOUT - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   CH_LAST  = CW'(CH - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state;
  logic [7:0]      frameMem [CH][FRAME_LEN];
  logic [CNTW-1:0] cnt      [CH];
  logic [IDW-1:0]  idle     [CH];
  logic [CH-1:0]   accept;
  logic [CW-1:0]   rdCh;
  logic [IW-1:0]   rdIdx;
  logic            ptrValid;
  logic            drainEnd;
  logic            rdIsFill;

  // A byte is taken only while collecting, into a non-full, unlocked channel.
  always_comb begin
    accept = '0;
    for (int k = 0; k < CH; k++) begin
      accept[k] = bus.iValid[k] && (cnt[k] < CNT_FULL) && !bus.oTmo[k] && (state == IDLE);
    end
  end

  // The pointer has run past the last address: this is the clock after the last oValid.
  assign drainEnd = (state == DRAIN) && !ptrValid;
  assign rdIsFill = CNTW'(rdIdx) >= cnt[rdCh];

  always_comb begin
    bus.oComplete = '0;
    for (int k = 0; k < CH; k++) begin
      bus.oComplete[k] = (cnt[k] == CNT_FULL);
    end
  end

  // Frame buffers: every channel writes its own row in parallel; contents need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CH; k++) begin
      if (accept[k]) begin
        frameMem[k][cnt[k][IW-1:0]] <= bus.iData[8*k +: 8];
      end
    end
  end

  // Write counters, inter-byte timeout and overflow flags for each channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        cnt[k]  <= '0;
        idle[k] <= '0;
      end
      bus.oTmo <= '0;
      bus.oOvf <= '0;
    end else begin
      bus.oOvf <= bus.oOvf | (bus.iValid & ~accept);
      if (drainEnd) begin
        for (int k = 0; k < CH; k++) begin
          cnt[k]  <= '0;
          idle[k] <= '0;
        end
        bus.oTmo <= '0;
      end else begin
        for (int k = 0; k < CH; k++) begin
          if (accept[k]) begin
            cnt[k]  <= cnt[k] + 1'b1;
            idle[k] <= '0;
          end else if ((cnt[k] != '0) && (cnt[k] < CNT_FULL) && !bus.oTmo[k]) begin
            // The counter parks at its last value once the channel is locked.
            if (idle[k] == IDL_LAST) begin
              bus.oTmo[k] <= 1'b1;
            end else begin
              idle[k] <= idle[k] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Drain sequencer: synchronous buffer read, so the stream lags the pointer by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptrValid   <= 1'b0;
      rdCh       <= '0;
      rdIdx      <= '0;
      bus.oValid <= 1'b0;
      bus.oData  <= '0;
      bus.oCh    <= '0;
      bus.oIdx   <= '0;
      bus.oFill  <= 1'b0;
      bus.oDone  <= 1'b0;
      bus.oBusy  <= 1'b0;
    end else begin
      bus.oDone <= 1'b0;
      case (state)
        IDLE: begin
          bus.oValid <= 1'b0;
          bus.oFill  <= 1'b0;
          if (bus.iSync) begin
            state     <= DRAIN;
            ptrValid  <= 1'b1;
            rdCh      <= '0;
            rdIdx     <= '0;
            bus.oBusy <= 1'b1;
          end
        end
        DRAIN: begin
          if (ptrValid) begin
            bus.oValid <= 1'b1;
            bus.oData  <= rdIsFill ? FILL : frameMem[rdCh][rdIdx];
            bus.oFill  <= rdIsFill;
            bus.oCh    <= rdCh;
            bus.oIdx   <= rdIdx;
            // Explicit wrap so a non-power-of-two FRAME_LEN steps correctly.
            if (rdIdx == IDX_LAST) begin
              rdIdx <= '0;
              if (rdCh == CH_LAST) begin
                ptrValid <= 1'b0;
              end else begin
                rdCh <= rdCh + 1'b1;
              end
            end else begin
              rdIdx <= rdIdx + 1'b1;
            end
          end else begin
            bus.oValid <= 1'b0;
            bus.oFill  <= 1'b0;
            bus.oDone  <= 1'b1;
            bus.oBusy  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcb_rx_collector.sv
// Bench for lcb_rx_collector: randomized channel traffic against a queue-based
// model of the frame contents, drained stream, timeout lock and overflow flags.
module tb_lcb_rx_collector;
  localparam int CH      = 5;
  localparam int FL      = 16;
  localparam int TIMEOUT = 800;
  localparam int N       = CH * FL;
  localparam int CW      = $clog2(CH);
  localparam int IW      = $clog2(FL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcb_rx_collector_if #(.CH(CH), .FRAME_LEN(FL)) bus ();

  lcb_rx_collector #(.CH(CH), .FRAME_LEN(FL), .TIMEOUT(TIMEOUT), .FILL(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nTotal = 0;
  int nPass  = 0;
  int cyc    = 0;

  // Reference model: received bytes per channel, overflow flags, time of last accepted byte.
  logic [7:0] mq [CH][$];
  bit         mOvf [CH];
  int         lastAcc [CH];
  bit         draining = 1'b0;
  logic [7:0] expData [N];
  bit         expFill [N];
  int         want [CH];

  function automatic bit mTmo(int k);
    return (mq[k].size() > 0) && (mq[k].size() < FL) && ((cyc - lastAcc[k]) >= TIMEOUT);
  endfunction

  function automatic logic [CH-1:0] vecComplete();
    logic [CH-1:0] r = '0;
    for (int k = 0; k < CH; k++) r[k] = (mq[k].size() == FL);
    return r;
  endfunction

  function automatic logic [CH-1:0] vecTmo();
    logic [CH-1:0] r = '0;
    for (int k = 0; k < CH; k++) r[k] = mTmo(k);
    return r;
  endfunction

  function automatic logic [CH-1:0] vecOvf();
    logic [CH-1:0] r = '0;
    for (int k = 0; k < CH; k++) r[k] = mOvf[k];
    return r;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < CH; k++) begin
      mq[k].delete();
      mOvf[k]    = 1'b0;
      lastAcc[k] = 0;
    end
    draining = 1'b0;
  endfunction

  // One clock: drive inputs, update the model with what the design should do at this edge.
  task automatic step(input logic [CH-1:0] v, input logic [8*CH-1:0] d, input logic s, input logic r);
    bus.iValid = v;
    bus.iData  = d;
    bus.iSync  = s;
    rst        = r;
    if (r) begin
      modelReset();
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (v[k]) begin
          if (!draining && mq[k].size() < FL && !mTmo(k)) begin
            mq[k].push_back(d[8*k +: 8]);
            lastAcc[k] = cyc + 1;
          end else begin
            mOvf[k] = 1'b1;
          end
        end
      end
      if (s && !draining) begin
        draining = 1'b1;
        for (int i = 0; i < N; i++) begin
          if ((i % FL) < mq[i / FL].size()) begin
            expData[i] = mq[i / FL][i % FL];
            expFill[i] = 1'b0;
          end else begin
            expData[i] = 8'hFF;
            expFill[i] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill_random();
    int rem [CH];
    logic [CH-1:0] v;
    logic [8*CH-1:0] d;
    bit more;
    int guard;
    guard = 0;
    more  = 1'b0;
    for (int k = 0; k < CH; k++) begin
      rem[k] = want[k];
      if (rem[k] > 0) more = 1'b1;
    end
    while (more && guard < 2000) begin
      guard++;
      v = '0;
      d = '0;
      for (int k = 0; k < CH; k++) begin
        d[8*k +: 8] = 8'($urandom);
        if (rem[k] > 0 && $urandom_range(1, 0) == 1) begin
          v[k] = 1'b1;
          rem[k]--;
        end
      end
      step(v, d, 1'b0, 1'b0);
      more = 1'b0;
      for (int k = 0; k < CH; k++) if (rem[k] > 0) more = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    nTotal++;
    if (bus.oComplete !== vecComplete() || bus.oTmo !== vecTmo() || bus.oOvf !== vecOvf())
      $display("FAIL %s status: complete=%b tmo=%b ovf=%b, expected complete=%b tmo=%b ovf=%b",
               tag, bus.oComplete, bus.oTmo, bus.oOvf, vecComplete(), vecTmo(), vecOvf());
    else nPass++;
  endtask

  // iSync (optionally with same-clock bytes), then check every clock of the drain.
  task automatic run_drain(input logic [CH-1:0] sv, input logic [8*CH-1:0] sd, input int strayCh,
                           input int strayAt, input int syncAt, input int rstAt, input string tag);
    logic [CH-1:0] v;
    logic s, r;
    logic [CW-1:0] eCh;
    logic [IW-1:0] eIdx;
    step(sv, sd, 1'b1, 1'b0);
    for (int j = 1; j <= N + 2; j++) begin
      v = '0;
      if (j == strayAt) v[strayCh] = 1'b1;
      s = (j == syncAt);
      r = (j == rstAt);
      step(v, {CH{8'h5A}}, s, r);
      if (r) begin
        nTotal++;
        if (bus.oValid !== 1'b0 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0)
          $display("FAIL %s rst_stop: valid=%b done=%b busy=%b, expected 0 0 0",
                   tag, bus.oValid, bus.oDone, bus.oBusy);
        else nPass++;
        return;
      end
      if (j <= N) begin
        eCh  = CW'((j - 1) / FL);
        eIdx = IW'((j - 1) % FL);
        nTotal++;
        if (bus.oValid !== 1'b1 || bus.oData !== expData[j-1] || bus.oCh !== eCh || bus.oIdx !== eIdx ||
            bus.oFill !== expFill[j-1] || bus.oDone !== 1'b0 || bus.oBusy !== 1'b1)
          $display("FAIL %s byte%0d: valid=%b data=%h ch=%0d idx=%0d fill=%b done=%b busy=%b, expected 1 %h %0d %0d %b 0 1",
                   tag, j - 1, bus.oValid, bus.oData, bus.oCh, bus.oIdx, bus.oFill, bus.oDone, bus.oBusy,
                   expData[j-1], eCh, eIdx, expFill[j-1]);
        else nPass++;
      end else if (j == N + 1) begin
        nTotal++;
        if (bus.oValid !== 1'b0 || bus.oDone !== 1'b1 || bus.oBusy !== 1'b0)
          $display("FAIL %s done: valid=%b done=%b busy=%b, expected 0 1 0", tag, bus.oValid, bus.oDone, bus.oBusy);
        else nPass++;
        for (int k = 0; k < CH; k++) mq[k].delete();
        draining = 1'b0;
      end else begin
        nTotal++;
        if (bus.oValid !== 1'b0 || bus.oDone !== 1'b0)
          $display("FAIL %s after_done: valid=%b done=%b, expected 0 0", tag, bus.oValid, bus.oDone);
        else nPass++;
      end
    end
  endtask

  task automatic test_reset();
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    nTotal++;
    if (bus.oValid !== 1'b0 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0 || bus.oFill !== 1'b0)
      $display("FAIL reset_ctrl: valid=%b done=%b busy=%b fill=%b, expected 0 0 0 0",
               bus.oValid, bus.oDone, bus.oBusy, bus.oFill);
    else nPass++;
    nTotal++;
    if (bus.oData !== 8'h00 || bus.oCh !== '0 || bus.oIdx !== '0)
      $display("FAIL reset_data: data=%h ch=%0d idx=%0d, expected 00 0 0", bus.oData, bus.oCh, bus.oIdx);
    else nPass++;
    check_status("reset");
    idle(1);
  endtask

  task automatic test_full_frames();
    logic [8*CH-1:0] d;
    for (int i = 0; i < FL; i++) begin
      for (int k = 0; k < CH; k++) d[8*k +: 8] = 8'(8'h10 * k + i);
      step('1, d, 1'b0, 1'b0);
    end
    idle(2);
    nTotal++;
    if (bus.oComplete !== {CH{1'b1}})
      $display("FAIL full_complete: got %b, expected all ones", bus.oComplete);
    else nPass++;
    run_drain('0, '0, 0, 0, 0, 0, "full");
    check_status("full_after");
  endtask

  task automatic test_partial();
    want = '{16, 16, 5, 16, 0};
    fill_random();
    check_status("partial_before");
    run_drain('0, '0, 0, 0, 0, 0, "partial");
    check_status("partial_after");
  endtask

  task automatic test_timeout();
    logic [8*CH-1:0] d;
    for (int i = 0; i < 3; i++) begin
      d = {CH{8'($urandom)}};
      step(5'b00010, d, 1'b0, 1'b0);
    end
    while ((cyc - lastAcc[1]) < TIMEOUT - 1) idle(1);
    nTotal++;
    if (bus.oTmo[1] !== 1'b0) $display("FAIL tmo_early: got %b, expected 0", bus.oTmo[1]);
    else nPass++;
    idle(1);
    nTotal++;
    if (bus.oTmo[1] !== 1'b1) $display("FAIL tmo_set: got %b, expected 1", bus.oTmo[1]);
    else nPass++;
    check_status("tmo_locked");
    step(5'b00010, {CH{8'h44}}, 1'b0, 1'b0);
    check_status("tmo_drop");
    run_drain('0, '0, 0, 0, 0, 0, "tmo");
    check_status("tmo_after");
  endtask

  task automatic test_overflow();
    want = '{17, 16, $urandom_range(16, 0), $urandom_range(16, 0), 16};
    fill_random();
    check_status("ovf_17th");
    run_drain('0, '0, 3, 10, 0, 0, "ovf");
    check_status("ovf_after");
    idle(3);
    check_status("ovf_sticky");
  endtask

  task automatic test_back_to_back();
    logic [8*CH-1:0] d;
    want = '{15, 16, $urandom_range(16, 0), 16, $urandom_range(16, 0)};
    fill_random();
    d = {CH{8'($urandom)}};
    run_drain(5'b00001, d, 0, 0, 40, 0, "simul");
    check_status("simul_after");
  endtask

  task automatic test_reset_mid_drain();
    want = '{16, $urandom_range(16, 0), 16, $urandom_range(16, 0), 16};
    fill_random();
    run_drain('0, '0, 0, 0, 0, 31, "rstmid");
    check_status("rstmid_cleared");
    idle(1);
    want = '{$urandom_range(16, 0), 16, $urandom_range(16, 0), 16, $urandom_range(16, 0)};
    fill_random();
    run_drain('0, '0, 0, 0, 0, 0, "rstmid_fresh");
    check_status("rstmid_fresh_after");
  endtask

  task automatic test_random();
    logic [CH-1:0] sv;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < CH; k++) want[k] = $urandom_range(FL + 1, 0);
      fill_random();
      check_status("rand_before");
      sv = CH'($urandom);
      run_drain(sv, {CH{8'($urandom)}}, $urandom_range(CH - 1, 0), $urandom_range(N + 1, 1), 0, 0, "rand");
      check_status("rand_after");
    end
  endtask

  initial begin
    bus.iValid = '0;
    bus.iData  = '0;
    bus.iSync  = 1'b0;
    modelReset();
    test_reset();
    test_full_frames();
    test_partial();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
